// File: rtl/id_stage.sv
// Decode stage: latches fetched instructions, resolves LA32R branches/jumps,
// kills the wrong-path successor of a taken branch and stalls on load-use hazards.
module id_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fs_to_ds_valid,
    input  logic [63:0] fs_to_ds_bus,
    output logic        ds_allowin,
    output logic [33:0] br_bus,
    output logic [4:0]  rj_addr,
    output logic [4:0]  rkd_addr,
    input  logic [31:0] rj_value,
    input  logic [31:0] rkd_value,
    input  logic        es_load_valid,
    input  logic [4:0]  es_load_dest,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [63:0] ds_to_es_bus
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    logic            ds_valid;
    logic [XLEN-1:0] ds_pc;
    logic [XLEN-1:0] ds_inst;

    logic [OPW-1:0]  op6;
    logic            is_jirl, is_b, is_bl, is_cond, is_br;
    logic            is_store, is_lu12i, is_3r;
    logic            use_rj, use_rkd;
    logic            hazard, ds_ready_go, taken, br_taken, br_stall;
    logic [XLEN-1:0] offs16, offs26, tgt_base, tgt_offs, br_target;
    logic            eq, lt_s, lt_u;

    // Instruction classification
    assign op6      = ds_inst[31:26];
    assign is_jirl  = (op6 == OPW'(6'h13));
    assign is_b     = (op6 == OPW'(6'h14));
    assign is_bl    = (op6 == OPW'(6'h15));
    assign is_cond  = (op6 >= OPW'(6'h16)) && (op6 <= OPW'(6'h1b));
    assign is_br    = is_jirl | is_b | is_bl | is_cond;
    assign is_store = (ds_inst[31:22] == 10'h0a4) || (ds_inst[31:22] == 10'h0a5)
                   || (ds_inst[31:22] == 10'h0a6);
    assign is_lu12i = (ds_inst[31:25] == 7'h0a);
    assign is_3r    = (ds_inst[31:20] == 12'h001);

    assign rj_addr  = ds_inst[9:5];
    assign rkd_addr = (is_cond | is_store) ? ds_inst[4:0] : ds_inst[14:10];
    assign use_rj   = ~(is_b | is_bl | is_lu12i);
    assign use_rkd  = is_cond | is_store | is_3r;

    // Load-use hazard against execute; r0 is never a real dependency
    assign hazard = ds_valid & es_load_valid & (es_load_dest != 5'd0)
                  & ((use_rj  & (rj_addr  == es_load_dest))
                   | (use_rkd & (rkd_addr == es_load_dest)));

    assign ds_ready_go    = ~hazard;
    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid & ds_ready_go;
    assign ds_to_es_bus   = {ds_pc, ds_inst};

    assign offs16 = {{14{ds_inst[25]}}, ds_inst[25:10], 2'b00};
    assign offs26 = {{4{ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b00};

    assign eq   = (rj_value == rkd_value);
    assign lt_s = ($signed(rj_value) < $signed(rkd_value));
    assign lt_u = (rj_value < rkd_value);

    // Branch condition
    always_comb begin
        taken = 1'b0;
        case (op6)
            6'h13, 6'h14, 6'h15: taken = 1'b1;
            6'h16:               taken = eq;
            6'h17:               taken = ~eq;
            6'h18:               taken = lt_s;
            6'h19:               taken = ~lt_s;
            6'h1a:               taken = lt_u;
            6'h1b:               taken = ~lt_u;
            default:             taken = 1'b0;
        endcase
    end

    // Target operands
    always_comb begin
        tgt_base = ds_pc;
        tgt_offs = offs16;
        if (is_jirl) begin
            tgt_base = rj_value;
        end else if (is_b | is_bl) begin
            tgt_offs = offs26;
        end
    end

    assign br_stall  = ds_valid & is_br & hazard;
    assign br_taken  = ds_valid & ds_ready_go & es_allowin & is_br & taken;
    assign br_target = br_taken ? XLEN'(tgt_base + tgt_offs) : '0;
    assign br_bus    = {br_stall, br_taken, br_target};

    // Decode register; the successor accepted alongside a taken branch is killed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
            ds_pc    <= '0;
            ds_inst  <= '0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid & ~br_taken;
            if (fs_to_ds_valid) begin
                ds_pc   <= fs_to_ds_bus[63:32];
                ds_inst <= fs_to_ds_bus[31:0];
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues expected decode->execute
// transfers (bus + branch bus); a monitor pops and compares on every transfer.
module tb_id_stage;

    logic        clk;
    logic        resetn;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        ds_allowin;
    logic [33:0] br_bus;
    logic [4:0]  rj_addr;
    logic [4:0]  rkd_addr;
    logic [31:0] rj_value;
    logic [31:0] rkd_value;
    logic        es_load_valid;
    logic [4:0]  es_load_dest;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [63:0] ds_to_es_bus;

    logic [31:0] rf [32];

    typedef struct packed {
        logic [63:0] bus;
        logic [33:0] br;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt;
    int   total_cnt;

    localparam logic [31:0] ADD_W   = 32'h00100C41; // add.w r1,r2,r3
    localparam logic [31:0] BEQ_45  = 32'h58001085; // beq r4,r5,+16
    localparam logic [31:0] BLTU_67 = 32'h680020C7; // bltu r6,r7,+32
    localparam logic [31:0] BLT_67  = 32'h600020C7; // blt r6,r7,+32
    localparam logic [31:0] JIRL_8  = 32'h4FFFFD01; // jirl r1,r8,-4
    localparam logic [31:0] BL_M16  = 32'h57FFF3FF; // bl -16
    localparam logic [31:0] BEQ_00  = 32'h58001000; // beq r0,r0,+16

    id_stage dut (
        .clk           (clk),
        .resetn        (resetn),
        .fs_to_ds_valid(fs_to_ds_valid),
        .fs_to_ds_bus  (fs_to_ds_bus),
        .ds_allowin    (ds_allowin),
        .br_bus        (br_bus),
        .rj_addr       (rj_addr),
        .rkd_addr      (rkd_addr),
        .rj_value      (rj_value),
        .rkd_value     (rkd_value),
        .es_load_valid (es_load_valid),
        .es_load_dest  (es_load_dest),
        .es_allowin    (es_allowin),
        .ds_to_es_valid(ds_to_es_valid),
        .ds_to_es_bus  (ds_to_es_bus)
    );

    assign rj_value  = rf[rj_addr];
    assign rkd_value = rf[rkd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Offer one instruction; returns just after the edge that accepted it, valid still high
    task automatic feed(input logic [31:0] pc, input logic [31:0] inst,
                        input bit exp_xfer, input logic [33:0] exp_br);
        bit ok;
        exp_t e;
        ok = 1'b0;
        if (exp_xfer) begin
            e.bus = {pc, inst};
            e.br  = exp_br;
            exp_q.push_back(e);
        end
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ds_allowin) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("feed_timeout", 64'(pc), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every decode->execute transfer must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && ds_to_es_valid && es_allowin) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", ds_to_es_bus, 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_bus", ds_to_es_bus, e.bus);
                    check("xfer_br", 64'(br_bus), 64'(e.br));
                end
            end
        end
    end

    initial begin
        pass_cnt       = 0;
        total_cnt      = 0;
        resetn         = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        es_load_valid  = 1'b0;
        es_load_dest   = '0;
        es_allowin     = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[4] = 32'd5;
        rf[5] = 32'd5;
        rf[6] = 32'hffffffff;
        rf[7] = 32'd1;
        rf[8] = 32'h1c001001;

        #12;
        check("rst_allowin", 64'(ds_allowin), 64'(1));
        check("rst_valid", 64'(ds_to_es_valid), 64'(0));
        check("rst_br", 64'(br_bus), 64'(0));
        check("rst_bus", ds_to_es_bus, 64'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(1);

        // Straight line
        feed(32'h1c000000, ADD_W, 1'b1, 34'd0);
        feed(32'h1c000004, ADD_W, 1'b1, 34'd0);
        idle(2);

        // beq taken; successor killed, target instruction flows
        feed(32'h1c000010, BEQ_45, 1'b1, {2'b01, 32'h1c000020});
        feed(32'h1c000014, ADD_W, 1'b0, 34'd0);
        check("kill_no_valid", 64'(ds_to_es_valid), 64'(0));
        feed(32'h1c000020, ADD_W, 1'b1, 34'd0);
        idle(2);

        // bltu not taken, blt taken on the same operands
        feed(32'h1c000030, BLTU_67, 1'b1, 34'd0);
        feed(32'h1c000034, BLT_67, 1'b1, {2'b01, 32'h1c000054});
        idle(2);

        // jirl and bl with negative offsets
        feed(32'h1c000100, JIRL_8, 1'b1, {2'b01, 32'h1c000ffd});
        idle(2);
        feed(32'h1c000000, BL_M16, 1'b1, {2'b01, 32'h1bfffff0});
        idle(2);

        // Load-use stall on r4
        es_load_valid = 1'b1;
        es_load_dest  = 5'd4;
        feed(32'h1c000200, BEQ_45, 1'b1, {2'b01, 32'h1c000210});
        fs_to_ds_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_br_stall", 64'(br_bus[33]), 64'(1));
            check("stall_br_taken", 64'(br_bus[32]), 64'(0));
            check("stall_allowin", 64'(ds_allowin), 64'(0));
            check("stall_valid", 64'(ds_to_es_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        es_load_valid = 1'b0;
        @(negedge clk);
        check("unstall_br_stall", 64'(br_bus[33]), 64'(0));
        idle(2);

        // Load dest r0 never stalls
        es_load_valid = 1'b1;
        es_load_dest  = 5'd0;
        feed(32'h1c000300, BEQ_00, 1'b1, {2'b01, 32'h1c000310});
        fs_to_ds_valid = 1'b0;
        @(negedge clk);
        check("r0_no_stall", 64'(br_bus[33]), 64'(0));
        check("r0_valid", 64'(ds_to_es_valid), 64'(1));
        es_load_valid = 1'b0;
        idle(2);

        // Backpressure hold, then async reset mid-hold
        es_allowin = 1'b0;
        feed(32'h1c000500, BEQ_45, 1'b0, 34'd0);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {32'h1c000504, ADD_W};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_allowin", 64'(ds_allowin), 64'(0));
            check("hold_bus", ds_to_es_bus, {32'h1c000500, BEQ_45});
            check("hold_br", 64'(br_bus), 64'(0));
        end
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(ds_to_es_valid), 64'(0));
        check("arst_br", 64'(br_bus), 64'(0));
        check("arst_allowin", 64'(ds_allowin), 64'(1));
        check("arst_bus", ds_to_es_bus, 64'(0));
        fs_to_ds_valid = 1'b0;
        es_allowin     = 1'b1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        idle(4);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage in-order pipeline, sitting between the fetch stage and the execute stage. It latches `fs_to_ds_bus` ({pc, inst}) under a valid/allowin handshake and resolves all LA32R branches and jumps in this stage. It drives `br_bus` ({br_stall, br_taken, br_target}) back to fetch, discards the wrong-path instruction that follows a taken branch, and stalls on load-use hazards against the execute stage.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `fs_to_ds_valid`  in  1  fetch offers an instruction.
- `fs_to_ds_bus`  in  64  {fs_pc[63:32], fs_inst[31:0]}.
- `ds_allowin`  out  1  decode can accept this cycle.
- `br_bus`  out  34  {br_stall[33], br_taken[32], br_target[31:0]}.
- `rj_addr`  out  5  register-file read port 1 address = ds_inst[9:5].
- `rkd_addr`  out  5  read port 2: ds_inst[4:0] for conditional branch/store, else ds_inst[14:10].
- `rj_value`  in  32  forwarded value for `rj_addr` (regfile + bypass, external).
- `rkd_value`  in  32  forwarded value for `rkd_addr`.
- `es_load_valid`  in  1  execute stage holds a valid load.
- `es_load_dest`  in  5  destination register of that load.
- `es_allowin`  in  1  execute can accept.
- `ds_to_es_valid`  out  1  decode offers an instruction.
- `ds_to_es_bus`  out  64  {ds_pc, ds_inst}.

## Operation
- Registers: `ds_valid`, `ds_pc[31:0]`, `ds_inst[31:0]`.
- Classification on ds_inst[31:26]:
  - jirl 0x13, b 0x14, bl 0x15.
  - beq 0x16, bne 0x17, blt 0x18, bge 0x19, bltu 0x1a, bgeu 0x1b.
- Stores: ds_inst[31:22] ∈ {0x0a4, 0x0a5, 0x0a6}.
- Offsets:
  - offs16 = sext({ds_inst[25:10], 2'b00}).
  - offs26 = sext({ds_inst[9:0], ds_inst[25:10], 2'b00}).
- Target, 32-bit wrap-around add:
  - b/bl: ds_pc + offs26.
  - conditional branches: ds_pc + offs16.
  - jirl: rj_value + offs16.
- Condition: compare rj_value vs rkd_value.
  - beq/bne: equality.
  - blt/bge: signed compare.
  - bltu/bgeu: unsigned compare.
  - b/bl/jirl: always taken.
- Source use:
  - rj is read by every instruction except b, bl and lu12i.w (ds_inst[31:25]=0x0a).
  - rkd is read by conditional branches, stores and 3R ops (ds_inst[31:20]=0x001).
- `hazard` = ds_valid & es_load_valid & es_load_dest≠0 & (used rj == es_load_dest or used rkd == es_load_dest).
- `ds_ready_go` = ~hazard.
- `ds_allowin` = ~ds_valid | (ds_ready_go & es_allowin).
- `ds_to_es_valid` = ds_valid & ds_ready_go.
- `br_stall` = ds_valid & is_branch_or_jump & hazard.
- `br_taken` = ds_valid & ds_ready_go & es_allowin & taken. It is never asserted while br_stall is asserted.
- `br_target` = computed target whenever br_taken; 0 otherwise.
- Wrong-path kill: in a cycle with br_taken=1, any instruction accepted from fetch is the sequential successor. Set `ds_valid` <= 0 for it (pc/inst may load; don't-care).

## Timing
- Reset (async, while resetn=0):
  - ds_valid=0, ds_pc=0, ds_inst=0.
  - Hence ds_to_es_valid=0, br_bus=0, ds_allowin=1.
  - Reset mid-operation drops the in-flight instruction immediately.
- Latch rule: on clk edge with ds_allowin=1:
  - ds_valid <= fs_to_ds_valid & ~br_taken.
  - {ds_pc, ds_inst} <= fs_to_ds_bus when fs_to_ds_valid.
- Hold: with ds_allowin=0, all registers hold.
- br_bus, ds_to_es_valid, ds_allowin, rj_addr and rkd_addr are combinational from registered state plus inputs. There is no registered latency on branch redirect: fetch samples target on the same edge the branch leaves decode.
- Latency: one cycle fetch→decode register; decode→execute transfer on ds_to_es_valid & es_allowin.
- Simultaneous hazard and es_allowin=1: no transfer, no br_taken.
- Simultaneous taken branch leaving and fetch offering: the branch transfers and the offered instruction is killed.
- Hazard clears when the load leaves execute (es_load_valid drops). The instruction proceeds in that same cycle.
- rd=0 as a load dest never causes a stall.

## Test plan
- Straight line: IF supplies pc 0x1c000000, 0x1c000004 (add.w) with es_allowin=1 → ds_to_es_bus pcs appear one cycle later each, br_bus=0.
- beq taken: pc 0x1c000010, offs16=4, rj_value=rkd_value=5 → br_taken=1, br_target=0x1c000020; the next accepted instruction (0x1c000014) never reaches ds_to_es_valid.
- bltu vs blt: rj=0xffffffff, rkd=1 → bltu not taken (br_taken=0), blt taken.
- jirl: rj_value=0x1c001001, offs16=-4 → br_target=0x1c000ffd. bl at 0x1c000000 with offs26=0x3fffffc (−16 bytes) → target 0x1bfffff0.
- Load-use: beq reading r4 while es_load_valid=1, es_load_dest=4 → br_stall=1, br_taken=0, ds_allowin=0 for the whole stall. Next cycle es_load_valid=0 → branch resolves, br_stall=0. Same case with es_load_dest=0 → no stall.
- Backpressure/reset: es_allowin=0 for 3 cycles holds ds_pc/ds_inst and ds_allowin=0. Asserting resetn=0 mid-hold clears ds_valid and br_bus asynchronously.
